// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude compare controller.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for a given slice count; never narrower than one bit.
  function automatic int cnt_width(input int slices);
    int w;
    w = $clog2(slices);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int WIDTH_DEF = 8;
  localparam int SLICES    = WIDTH_DEF / 2;
  localparam int CNT_W     = cnt_width(SLICES);

endpackage

// File: rtl/comparator.sv
// 2-bit unsigned magnitude comparator slice, pure dataflow.
module comparator (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Compares two WIDTH-bit unsigned operands two bits per cycle, MSB pair first,
// stopping at the first unequal pair. Results are registered, done pulses once.
module serial_mag_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output state_t           dbg_state_o
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = cnt_width(NSLICE);

  // Handshake: start is taken only on an edge where busy=0; done is a
  // one-cycle pulse and the result outputs are valid from that cycle on.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic             s_gt, s_lt, s_eq;

  comparator u_slice (
    .a  (sa_q[WIDTH-1 -: 2]),
    .b  (sb_q[WIDTH-1 -: 2]),
    .gt (s_gt),
    .lt (s_lt),
    .eq (s_eq)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(NSLICE - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (!s_eq) begin
          gt_d    = s_gt;
          lt_d    = s_lt;
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          sa_d  = sa_q << 2;
          sb_d  = sb_q << 2;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign a_gt_b      = gt_q;
  assign a_lt_b      = lt_q;
  assign a_eq_b      = eq_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Bench for serial_mag_compare_ctrl (WIDTH=8): directed scenarios plus a random sweep.
module tb_serial_mag_compare_ctrl;
  import cmp_pkg::*;

  localparam int W  = 8;
  localparam int EW = 35;  // {done cycle[31:0], gt, lt, eq}

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, a_gt_b, a_lt_b, a_eq_b;
  state_t       dbg_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  logic [EW-1:0] exp_q[$];

  serial_mag_compare_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_gt_b      (a_gt_b),
    .a_lt_b      (a_lt_b),
    .a_eq_b      (a_eq_b),
    .dbg_state_o (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: result from arithmetic compare, latency from MSB-first pair scan
  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
    return {x > y, x < y, x == y};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int k = 0; k < W/2; k++) begin
      if (x[W-1-2*k -: 2] != y[W-1-2*k -: 2]) return k + 1;
    end
    return W/2;
  endfunction

  // Driver: sync=1 waits for a falling edge first; otherwise drives immediately
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input bit sync);
    logic busy_s;
    int   c0;
    if (sync) @(negedge clk);
    busy_s = busy;
    start  = 1'b1;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!busy_s && !rst) begin
      c0 = cyc;
      exp_q.push_back({32'(c0 + ref_lat(av, bv)), ref_res(av, bv)});
      acc_cnt++;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (done === 1'b1) begin
      done_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_done cyc=%0d got done=1 required no done", cyc);
      end else begin
        e = exp_q.pop_front();
        if ({a_gt_b, a_lt_b, a_eq_b} !== e[2:0] || cyc !== int'(e[34:3]) || busy !== 1'b0)
          $display("FAIL result cyc=%0d got gt/lt/eq=%b busy=%b required %b at cyc %0d busy=0",
                   cyc, {a_gt_b, a_lt_b, a_eq_b}, busy, e[2:0], int'(e[34:3]));
        else
          pass_cnt++;
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_timeout got %0d pending required 0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic check_outs(input string name, input logic [4:0] req);
    chk_cnt++;
    if ({busy, done, a_gt_b, a_lt_b, a_eq_b} !== req)
      $display("FAIL %s got busy/done/gt/lt/eq=%b required %b", name,
               {busy, done, a_gt_b, a_lt_b, a_eq_b}, req);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset_outputs", 5'b00000);
    chk_cnt++;
    if (dbg_state !== IDLE) $display("FAIL reset_state got %0d required IDLE", dbg_state);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_msb_diff();
    do_start(8'hC0, 8'h40, 1);
    wait_drain("msb_diff");
    check_outs("msb_diff_hold", 5'b00100);
  endtask

  task automatic test_eq_ignored();
    do_start(8'h5A, 8'h5A, 1);
    @(negedge clk);
    do_start(8'hFF, 8'h00, 1);  // busy: must be ignored
    wait_drain("eq_ignored");
    repeat (3) @(negedge clk);
    check_outs("eq_hold", 5'b00001);
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(8'h11, 8'h12, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 10);
    chk_cnt++;
    if (done !== 1'b1) $display("FAIL b2b_first_done_timeout got done=%b required 1", done);
    else pass_cnt++;
    do_start(8'h80, 8'h7F, 0);
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    do_start(8'h03, 8'h03, 1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    acc_cnt--;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outs("reset_mid_outputs", 5'b00000);
    repeat (5) @(negedge clk);
    do_start(8'h02, 8'h01, 1);
    wait_drain("after_reset");
    check_outs("after_reset_hold", 5'b00100);
  endtask

  task automatic test_random();
    int n;
    acc_cnt  = 0;
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      do_start(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 0);
      if ($urandom_range(0, 3) == 0) do_start(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (busy !== 1'b0 && n < 10);
      repeat ($urandom_range(0, 1) * $urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("random");
    chk_cnt++;
    if (done_cnt !== acc_cnt) $display("FAIL random_done_count got %0d required %0d", done_cnt, acc_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_msb_diff();
    test_eq_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
